// File: rtl/mod_window3x3_pkg.sv
// Shared definitions for the 3x3 window generator: FSM encoding, luma coefficients
// and the (row, col) -> window element index mapping.
package mod_window3x3_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int LUMA_R     = 77;
    localparam int LUMA_G     = 150;
    localparam int LUMA_B     = 29;
    localparam int LUMA_SHIFT = 8;

    localparam int WIN_ROWS = 3;
    localparam int WIN_COLS = 3;

    // Element (r,c) lives at [PIX_W*win_idx(r,c) +: PIX_W]; r=0 top, c=0 left.
    function automatic int win_idx(input int r, input int c);
        return WIN_COLS * r + c;
    endfunction

endpackage

// File: rtl/mod_window3x3_linebuf.sv
// One line of pixel storage: synchronous write, combinational read.
// Contents are not reset; only rows already written in the current frame are consumed.
module mod_linebuf #(
    parameter  int DEPTH = 640,
    parameter  int W     = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mod_window3x3.sv
// Streaming 3x3 neighbourhood generator feeding mod_edge: two line buffers, one window per
// interior pixel. Define WIN_GRAY_EN to accept 24-bit {R,G,B} input converted to luma on entry.
module mod_window3x3
    import mod_window3x3_pkg::*;
#(
    parameter  int MAX_WIDTH = 640,
    parameter  int PIX_W     = 8,
    parameter  int DIM_W     = 16,
`ifdef WIN_GRAY_EN
    localparam int IN_W      = 24
`else
    localparam int IN_W      = PIX_W
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DIM_W-1:0]   width,
    input  logic [DIM_W-1:0]   height,
    input  logic               start,
    output logic               done,
    output logic               err,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [9*PIX_W-1:0] out_win,
    output logic [DIM_W-1:0]   out_x,
    output logic [DIM_W-1:0]   out_y,
    output state_t             dbg_state
);

    localparam int AW = $clog2(MAX_WIDTH);

    state_t             r_state, w_state_nxt;
    logic [DIM_W-1:0]   r_width, r_height, r_x, r_y;
    logic               r_last, r_err, r_out_valid;
    logic [9*PIX_W-1:0] r_out_win, w_next_win;
    logic [DIM_W-1:0]   r_out_x, r_out_y;
    logic [PIX_W-1:0]   r_col [2][3];
    logic [PIX_W-1:0]   w_pix, w_lb0_rd, w_lb1_rd;
    logic [AW-1:0]      w_addr;
    logic               w_dim_bad, w_in_ready, w_acc, w_x_wrap, w_emit;

`ifdef WIN_GRAY_EN
    logic [15:0] w_luma;
    assign w_luma = 16'(LUMA_R) * 16'(in_data[23:16])
                  + 16'(LUMA_G) * 16'(in_data[15:8])
                  + 16'(LUMA_B) * 16'(in_data[7:0]);
    assign w_pix  = PIX_W'(w_luma >> LUMA_SHIFT);
`else
    assign w_pix  = in_data;
`endif

    assign w_dim_bad = (width < DIM_W'(3)) || (height < DIM_W'(3)) ||
                       (width > DIM_W'(MAX_WIDTH));
    // Both sides are valid/ready: a beat transfers on a rising edge where valid & ready are
    // high; valid never drops and data never changes while waiting for ready.
    assign w_in_ready = (r_state == RUN) && start && !r_last && (!r_out_valid || out_ready);
    assign w_acc      = in_valid && w_in_ready;
    assign w_x_wrap   = (r_x == r_width - DIM_W'(1));
    assign w_emit     = (r_x >= DIM_W'(2)) && (r_y >= DIM_W'(2));
    assign w_addr     = r_x[AW-1:0];

    mod_linebuf #(.DEPTH(MAX_WIDTH), .W(PIX_W)) u_lb0 (
        .clk     (clk),
        .i_we    (w_acc),
        .i_waddr (w_addr),
        .i_wdata (w_lb1_rd),
        .i_raddr (w_addr),
        .o_rdata (w_lb0_rd)
    );

    mod_linebuf #(.DEPTH(MAX_WIDTH), .W(PIX_W)) u_lb1 (
        .clk     (clk),
        .i_we    (w_acc),
        .i_waddr (w_addr),
        .i_wdata (w_pix),
        .i_raddr (w_addr),
        .o_rdata (w_lb1_rd)
    );

    // Two stored columns plus the column arriving this cycle form the window.
    always_comb begin
        w_next_win = '0;
        for (int r = 0; r < WIN_ROWS; r++) begin
            w_next_win[PIX_W*win_idx(r, 0) +: PIX_W] = r_col[0][r];
            w_next_win[PIX_W*win_idx(r, 1) +: PIX_W] = r_col[1][r];
        end
        w_next_win[PIX_W*win_idx(0, 2) +: PIX_W] = w_lb0_rd;
        w_next_win[PIX_W*win_idx(1, 2) +: PIX_W] = w_lb1_rd;
        w_next_win[PIX_W*win_idx(2, 2) +: PIX_W] = w_pix;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = w_dim_bad ? DONE : RUN;
                end
            end
            RUN: begin
                if (!start) begin
                    w_state_nxt = IDLE;
                end else if (r_last && !r_out_valid) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (!start) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_width     <= '0;
            r_height    <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_last      <= 1'b0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_win   <= '0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            for (int c = 0; c < 2; c++) begin
                for (int r = 0; r < 3; r++) begin
                    r_col[c][r] <= '0;
                end
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_width     <= width;
                        r_height    <= height;
                        r_x         <= '0;
                        r_y         <= '0;
                        r_last      <= 1'b0;
                        r_err       <= w_dim_bad;
                        r_out_valid <= 1'b0;
                    end
                end
                RUN: begin
                    if (!start) begin
                        r_out_valid <= 1'b0;
                    end else if (w_acc) begin
                        r_col[0]    <= r_col[1];
                        r_col[1][0] <= w_lb0_rd;
                        r_col[1][1] <= w_lb1_rd;
                        r_col[1][2] <= w_pix;
                        if (w_x_wrap) begin
                            r_x <= '0;
                            if (r_y == r_height - DIM_W'(1)) begin
                                r_last <= 1'b1;
                            end else begin
                                r_y <= r_y + DIM_W'(1);
                            end
                        end else begin
                            r_x <= r_x + DIM_W'(1);
                        end
                        // Acceptance implies the output slot is empty or draining now.
                        r_out_valid <= w_emit;
                        if (w_emit) begin
                            r_out_win <= w_next_win;
                            r_out_x   <= r_x - DIM_W'(1);
                            r_out_y   <= r_y - DIM_W'(1);
                        end
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                DONE: begin
                    if (!start) begin
                        r_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done      = (r_state == DONE);
    assign err       = r_err;
    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_win   = r_out_win;
    assign out_x     = r_out_x;
    assign out_y     = r_out_y;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mod_window3x3.sv
// Bench for mod_window3x3: random frames against a direct 3x3 neighbourhood model.
// Build with WIN_GRAY_EN defined to also cover the RGB-to-luma input path.
module tb_mod_window3x3;

    localparam int MAX_WIDTH = 640;
    localparam int PIX_W     = 8;
    localparam int DIM_W     = 16;
`ifdef WIN_GRAY_EN
    localparam int IN_W      = 24;
`else
    localparam int IN_W      = PIX_W;
`endif
    localparam int WIN_W     = 9 * PIX_W;
    localparam int ITEM_W    = 2 * DIM_W + WIN_W;

    logic               clk = 1'b0;
    logic               rst;
    logic [DIM_W-1:0]   width, height;
    logic               start;
    logic               done, err;
    logic               in_valid, in_ready;
    logic [IN_W-1:0]    in_data;
    logic               out_valid, out_ready;
    logic [WIN_W-1:0]   out_win;
    logic [DIM_W-1:0]   out_x, out_y;
    mod_window3x3_pkg::state_t dbg_state;

    mod_window3x3 #(.MAX_WIDTH(MAX_WIDTH), .PIX_W(PIX_W), .DIM_W(DIM_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .width     (width),
        .height    (height),
        .start     (start),
        .done      (done),
        .err       (err),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_win   (out_win),
        .out_x     (out_x),
        .out_y     (out_y),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errs   = 0;
    logic [ITEM_W-1:0] exp_q[$];
    logic [ITEM_W-1:0] got_q[$];
    logic [IN_W-1:0]   pix[$];
    int                gray[$];
    int                ready_mode = 0;
    int                stall_cnt  = 0;
    logic              in_ready_seen = 1'b0;
    logic              hold_pending  = 1'b0;
    logic [ITEM_W-1:0] held;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [IN_W-1:0] mk(input int v);
        logic [7:0] b;
        b = 8'(v);
`ifdef WIN_GRAY_EN
        return {b, b, b};
`else
        return IN_W'(b);
`endif
    endfunction

    function automatic int luma(input logic [IN_W-1:0] p);
`ifdef WIN_GRAY_EN
        int rr, gg, bb;
        rr = int'(p[23:16]);
        gg = int'(p[15:8]);
        bb = int'(p[7:0]);
        return ((77 * rr + 150 * gg + 29 * bb) >> 8) & 255;
`else
        return int'(p);
`endif
    endfunction

    // Reference: every interior centre (x,y) gets the 3x3 block of gray values around it.
    task automatic build_model(input int w, input int h);
        logic [WIN_W-1:0] win;
        gray.delete();
        foreach (pix[i]) gray.push_back(luma(pix[i]));
        for (int y = 1; y < h - 1; y++) begin
            for (int x = 1; x < w - 1; x++) begin
                win = '0;
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        win[PIX_W*(3*r+c) +: PIX_W] = PIX_W'(gray[(y - 1 + r) * w + (x - 1 + c)]);
                    end
                end
                exp_q.push_back({DIM_W'(y), DIM_W'(x), win});
            end
        end
    endtask

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            hold_pending = 1'b0;
        end else begin
            if (in_ready) in_ready_seen = 1'b1;
            if (hold_pending) begin
                check_eq("hold_valid", out_valid, 1);
                check_eq("hold_data", {out_y, out_x, out_win}, held);
            end
            hold_pending = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    got_q.push_back({out_y, out_x, out_win});
                    if (exp_q.size() == 0) check_eq("window_expected", exp_q.size(), 1);
                    else check_eq("window", {out_y, out_x, out_win}, exp_q.pop_front());
                end else begin
                    held         = {out_y, out_x, out_win};
                    hold_pending = 1'b1;
                    check_eq("stall_in_ready", in_ready, 0);
                end
            end
        end
    end

    // ---------------- output ready driver ----------------
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: begin
                if (out_valid && stall_cnt < 5) begin
                    out_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    out_ready = 1'b1;
                end
            end
        endcase
    end

    // ---------------- input driver ----------------
    task automatic feed(input int n, input bit gaps, output int iters);
        int idx;
        idx   = 0;
        iters = 0;
        while (idx < n && iters < 40 * n + 100) begin
            @(posedge clk); #1;
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = pix[idx];
            @(negedge clk);
            iters++;
            if (in_valid && in_ready) idx++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("all_pixels_accepted", idx, n);
    endtask

    // kind: 0 ramp 4y+x, 1 random, 2 constant cval
    task automatic do_frame(input int w, input int h, input int kind, input logic [IN_W-1:0] cval,
                            input bit gaps, input int rmode, input bit exp_err, output int iters);
        int t;
        pix.delete();
        exp_q.delete();
        got_q.delete();
        for (int i = 0; i < w * h; i++) begin
            case (kind)
                0:       pix.push_back(mk(4 * (i / w) + (i % w)));
                1:       pix.push_back(IN_W'($urandom));
                default: pix.push_back(cval);
            endcase
        end
        if (!exp_err) build_model(w, h);
        ready_mode    = rmode;
        stall_cnt     = 0;
        in_ready_seen = 1'b0;
        iters         = 0;
        @(posedge clk); #1;
        width  = DIM_W'(w);
        height = DIM_W'(h);
        start  = 1'b1;
        if (!exp_err) feed(w * h, gaps, iters);
        t = 0;
        while (done !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check_eq("done", done, 1);
        check_eq("err", err, exp_err);
        check_eq("win_count", got_q.size(), exp_err ? 0 : (w - 2) * (h - 2));
        check_eq("exp_left", exp_q.size(), 0);
        if (exp_err) check_eq("no_in_ready", in_ready_seen, 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("done_clear", done, 0);
        check_eq("err_clear", err, 0);
        check_eq("back_idle", dbg_state, mod_window3x3_pkg::IDLE);
    endtask

    // ---------------- main sequence ----------------
    logic [WIN_W-1:0] lit0, lit1;
    logic [ITEM_W-1:0] item;
    int iters, idx, t;
    int bad_w[3] = '{2, 10, 641};
    int bad_h[3] = '{10, 2, 4};

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b1; width = '0; height = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_win", out_win, 0);
        check_eq("rst_out_xy", {out_y, out_x}, 0);
        check_eq("rst_state", dbg_state, mod_window3x3_pkg::IDLE);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                lit0[PIX_W*(3*r+c) +: PIX_W] = PIX_W'(4 * r + c);
                lit1[PIX_W*(3*r+c) +: PIX_W] = PIX_W'(4 * r + c + 1);
            end
        end

        // 4x3 ramp, free-flowing, then with a 5-cycle stall on the first window
        for (int m = 0; m < 2; m++) begin
            do_frame(4, 3, 0, '0, 1'b0, (m == 0) ? 0 : 2, 1'b0, iters);
            check_eq("ramp_win0", got_q[0], {DIM_W'(1), DIM_W'(1), lit0});
            check_eq("ramp_win1", got_q[1], {DIM_W'(1), DIM_W'(2), lit1});
        end

        for (int i = 0; i < 3; i++) begin
            do_frame(bad_w[i], bad_h[i], 1, '0, 1'b0, 0, 1'b1, iters);
        end

        do_frame(640, 4, 1, '0, 1'b0, 0, 1'b0, iters);
        check_eq("full_rate_cycles", iters, 640 * 4);

        do_frame(7, 6, 1, '0, 1'b1, 1, 1'b0, iters);
        do_frame(3, 3, 1, '0, 1'b1, 1, 1'b0, iters);

        // reset in the middle of a 5x5 frame, then a clean 5x5 frame
        pix.delete();
        exp_q.delete();
        for (int i = 0; i < 25; i++) pix.push_back(IN_W'($urandom));
        ready_mode = 0;
        @(posedge clk); #1;
        width = 16'd5; height = 16'd5; start = 1'b1;
        idx = 0; t = 0;
        while (idx < 7 && t < 100) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = pix[idx];
            @(negedge clk);
            t++;
            if (in_valid && in_ready) idx++;
        end
        check_eq("pre_rst_accepted", idx, 7);
        @(posedge clk); #2;
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", out_valid, 0);
        check_eq("mid_rst_in_ready", in_ready, 0);
        check_eq("mid_rst_done", done, 0);
        check_eq("mid_rst_err", err, 0);
        check_eq("mid_rst_out", {out_y, out_x, out_win}, 0);
        check_eq("mid_rst_state", dbg_state, mod_window3x3_pkg::IDLE);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        do_frame(5, 5, 1, '0, 1'b1, 1, 1'b0, iters);

`ifdef WIN_GRAY_EN
        begin
            logic [23:0] colours[3] = '{24'hFF0000, 24'hFFFFFF, 24'h00FF00};
            int          lumas[3]   = '{76, 255, 149};
            for (int k = 0; k < 3; k++) begin
                do_frame(4, 4, 2, colours[k], 1'b0, 0, 1'b0, iters);
                for (int w = 0; w < 4; w++) begin
                    item = got_q[w];
                    for (int e = 0; e < 9; e++) begin
                        check_eq("gray_elem", item[PIX_W*e +: PIX_W], lumas[k]);
                    end
                end
            end
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/mod_window3x3.md
Name: mod_window3x3

Overview:
- Streaming 3x3 neighbourhood generator that sits directly upstream of mod_edge.
- Accepts a raster-order pixel stream (as produced by mod_bmp / frame memory readout), holds two line buffers, and emits one 3x3 window per interior pixel.
- mod_edge applies its kernel to each window without doing its own row addressing.
- Frame-level control uses the same level start/done protocol as the other image blocks.

Parameters:
- MAX_WIDTH, 640: maximum line length; sets line-buffer depth.
- PIX_W, 8: bits per gray pixel.
- DIM_W, 16: width of the width/height/coordinate fields.

Ports:
- clk  input  1  system clock; everything is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- width  input  DIM_W  frame width in pixels; latched on start.
- height  input  DIM_W  frame height in pixels; latched on start.
- start  input  1  level request; held high until done is seen.
- done  output  1  frame complete; high while start is high after completion.
- err  output  1  illegal dimensions; valid while done=1.
- in_valid  input  1  input pixel valid.
- in_ready  output  1  input pixel accepted when in_valid & in_ready.
- in_data  input  IN_W  pixel. IN_W=24 with WIN_GRAY_EN, else PIX_W.
- out_valid  output  1  window valid.
- out_ready  input  1  consumer accepts when out_valid & out_ready.
- out_win  output  9*PIX_W  window; element (r,c) at [PIX_W*(3*r+c) +: PIX_W]. r=0 is the top row, c=0 the left column.
- out_x  output  DIM_W  centre column of the window.
- out_y  output  DIM_W  centre row of the window.

Behaviour:
- Reset: state=IDLE; done, err, in_ready, out_valid = 0; out_win, out_x, out_y = 0; x/y counters = 0. Line-buffer RAMs are not reset.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1, latch width and height.
  - If width<3, height<3 or width>MAX_WIDTH: go to DONE with err=1 and no transfers.
  - Otherwise go to RUN with x=y=0.
- RUN:
  - in_ready = !out_valid | out_ready.
  - On acceptance of pixel p at (x,y):
    - read lb1[x] (row y-1) and lb0[x] (row y-2);
    - write lb0[x]<=lb1[x] and lb1[x]<=p;
    - shift the 3-column register {lb0[x], lb1[x], p} in from the right.
  - Output register is loaded the cycle after acceptance, only if x>=2 and y>=2.
    - Window is centred at (x-1, y-1); out_x=x-1, out_y=y-1.
    - Latency is 1 cycle from acceptance to out_valid.
  - Window registers are ignored at x<2: no cross-row contamination.
  - Counter wrap: x increments; at x=width-1 it wraps to 0 and y increments.
  - out_valid holds its value and data stable until out_ready.
  - Simultaneous output drain and input acceptance is allowed, giving full throughput of 1 pixel/cycle.
  - Total windows per frame = (width-2)*(height-2). Border pixels produce no window; the edge stage zero-fills borders.
  - After pixel (width-1, height-1) is accepted, in_ready=0. Go to DONE once out_valid=0, i.e. the last window has drained.
  - start falling while in RUN: abort, clear out_valid, return to IDLE.
- DONE:
  - done=1; in_ready=0.
  - When start=0: done=0, err=0, go to IDLE.
- Async rst mid-frame returns to the reset state immediately; no window is emitted afterwards.

Optional Feature:
- WIN_GRAY_EN defined:
  - in_data is 24-bit {R,G,B} as read from a BMP.
  - Combinational luma before the line buffers: gray = (77*R + 150*G + 29*B) >> 8, using 16-bit intermediate arithmetic, then truncated to 8 bits. PIX_W must be 8.
  - Latency is unchanged.
- WIN_GRAY_EN undefined:
  - in_data is PIX_W bits and is stored unchanged.

Decomposition:
- Shared package:
  - state encoding localparams IDLE/RUN/DONE;
  - luma coefficients 77/150/29 and shift 8;
  - window-index helper constant for (r,c) -> slice offset.
- One sub-module: mod_linebuf, a single-port-read/single-port-write RAM of MAX_WIDTH x PIX_W with synchronous write and combinational read. Instantiate it twice (lb0, lb1).

Test Plan:
- 4x3 frame, pixel=4y+x, out_ready=1:
  - first window 0,1,2,4,5,6,8,9,10 at (1,1);
  - second window 1,2,3,5,6,7,9,10,11 at (2,1);
  - exactly 2 windows, then done=1, err=0.
- Same 4x3 frame with out_ready low for 5 cycles on the first window: out_valid and out_win stay stable, in_ready=0, no pixel is lost, results are identical.
- width=2, height=10: done=1 and err=1 without any in_ready assertion; start=0 -> done=0, IDLE.
- width=640, height=4, random pixels: 638*2=1276 windows, each matching a software 3x3 reference; throughput of 1 pixel/cycle with out_ready=1.
- rst pulsed after 7 pixels of a 5x5 frame: all outputs 0 immediately. A following fresh 5x5 frame produces 9 correct windows with no stale data.
- WIN_GRAY_EN: all pixels {255,0,0} -> every window element 76; all pixels {255,255,255} -> 255; all pixels {0,255,0} -> 149.
